// File: rtl/seq_mul_param_if.sv
// Handshake/operand bundle for seq_mul_param: requester drives start and
// operands, the multiplier returns busy, done and the registered product.
interface seq_mul_param_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     prod;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, prod
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, prod
  );
endinterface

// File: rtl/seq_mul_param.sv
// Sequential shift-add multiplier: magnitudes are multiplied unsigned over
// WIDTH cycles, then the sign is applied once in FIX. Fixed WIDTH+2 latency.
module seq_mul_param #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  seq_mul_param_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       count;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH-1:0]  acc;
  logic                neg;
  logic [2*WIDTH-1:0]  prod_q;

  logic                sm;
  logic [WIDTH-1:0]    abs_a;
  logic [WIDTH-1:0]    abs_b;
  logic [WIDTH:0]      sum;
  logic                last;

  assign sm    = bus.signed_mode & SIGNED_EN;
  assign abs_a = (sm && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b = (sm && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign last  = (count == CW'(WIDTH - 1));

  // The add carry lives only in sum; it is shifted straight into the top of
  // the accumulator, so no separate carry flop is needed between cycles.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last)      state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      mcand  <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      prod_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            neg   <= sm & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            mcand <= abs_a;
            acc   <= {{WIDTH{1'b0}}, abs_b};
            count <= '0;
          end
        end
        CALC: begin
          acc   <= {sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        FIX: begin
          prod_q <= neg ? -acc : acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state == CALC) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed bench for seq_mul_param: 8-bit signed-capable, 8-bit unsigned-only
// and 16-bit instances, each checked against hand-computed products.
module tb_seq_mul_param;

  logic clk;
  logic reset;
  int   check_count;
  int   pass_count;

  seq_mul_param_if #(.WIDTH(8))  if_m8 ();
  seq_mul_param_if #(.WIDTH(8))  if_u8 ();
  seq_mul_param_if #(.WIDTH(16)) if_m16 ();

  seq_mul_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_m8 (
    .clk(clk), .reset(reset), .bus(if_m8.slave)
  );
  seq_mul_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u8 (
    .clk(clk), .reset(reset), .bus(if_u8.slave)
  );
  seq_mul_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut_m16 (
    .clk(clk), .reset(reset), .bus(if_m16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream hangs despite the bounded loops.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // One 8-bit operation on m8 (sel=0) or u8 (sel=1); lat is the negedge index
  // after the accepting edge at which done was seen, -1 if never.
  task automatic applyStimulus(input bit sel, input logic sm, input logic [7:0] av,
                               input logic [7:0] bv, output logic [15:0] p,
                               output int lat, output logic busy_seen,
                               output logic done_after);
    @(negedge clk);
    if (sel) begin
      if_u8.start = 1'b1; if_u8.signed_mode = sm; if_u8.a = av; if_u8.b = bv;
    end else begin
      if_m8.start = 1'b1; if_m8.signed_mode = sm; if_m8.a = av; if_m8.b = bv;
    end
    @(negedge clk);
    if_m8.start = 1'b0;
    if_u8.start = 1'b0;
    busy_seen = sel ? if_u8.busy : if_m8.busy;
    lat = -1;
    p = '0;
    for (int i = 1; i <= 40; i++) begin
      if (sel ? if_u8.done : if_m8.done) begin
        lat = i;
        p = sel ? if_u8.prod : if_m8.prod;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = sel ? if_u8.done : if_m8.done;
  endtask

  task automatic applyStimulus16(input logic sm, input logic [15:0] av,
                                 input logic [15:0] bv, output logic [31:0] p,
                                 output int lat);
    @(negedge clk);
    if_m16.start = 1'b1; if_m16.signed_mode = sm; if_m16.a = av; if_m16.b = bv;
    @(negedge clk);
    if_m16.start = 1'b0;
    lat = -1;
    p = '0;
    for (int i = 1; i <= 60; i++) begin
      if (if_m16.done) begin
        lat = i;
        p = if_m16.prod;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if (if_m8.busy !== 1'b0 || if_m8.done !== 1'b0)
      $display("[TB] FAIL reset_m8_flags got busy=%b done=%b want 0 0", if_m8.busy, if_m8.done);
    else pass_count++;
    check_count++;
    if (if_m8.prod !== 16'h0000) $display("[TB] FAIL reset_m8_prod got %h want 0000", if_m8.prod);
    else pass_count++;
    check_count++;
    if (if_u8.busy !== 1'b0 || if_u8.done !== 1'b0 || if_u8.prod !== 16'h0000)
      $display("[TB] FAIL reset_u8 got busy=%b done=%b prod=%h want 0 0 0000",
               if_u8.busy, if_u8.done, if_u8.prod);
    else pass_count++;
    check_count++;
    if (if_m16.busy !== 1'b0 || if_m16.done !== 1'b0 || if_m16.prod !== 32'h0)
      $display("[TB] FAIL reset_m16 got busy=%b done=%b prod=%h want 0 0 00000000",
               if_m16.busy, if_m16.done, if_m16.prod);
    else pass_count++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [15:0] p; int lat; logic bs; logic da;
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'hFF, p, lat, bs, da);
    check_count++;
    if (p !== 16'hFE01) $display("[TB] FAIL uns_ff_prod got %h want fe01", p); else pass_count++;
    check_count++;
    if (lat !== 10) $display("[TB] FAIL uns_latency got %0d want 10", lat); else pass_count++;
    check_count++;
    if (bs !== 1'b1) $display("[TB] FAIL uns_busy got %b want 1", bs); else pass_count++;
    check_count++;
    if (da !== 1'b0) $display("[TB] FAIL uns_done_pulse got %b want 0", da); else pass_count++;
    applyStimulus(1'b0, 1'b0, 8'h0C, 8'h0D, p, lat, bs, da);
    check_count++;
    if (p !== 16'h009C) $display("[TB] FAIL uns_12x13 got %h want 009c", p); else pass_count++;
  endtask

  task automatic test_signed();
    logic [15:0] p; int lat; logic bs; logic da;
    applyStimulus(1'b0, 1'b1, 8'h80, 8'h80, p, lat, bs, da);
    check_count++;
    if (p !== 16'h4000) $display("[TB] FAIL sgn_min_min got %h want 4000", p); else pass_count++;
    applyStimulus(1'b0, 1'b1, 8'hFD, 8'h05, p, lat, bs, da);
    check_count++;
    if (p !== 16'hFFF1) $display("[TB] FAIL sgn_m3x5 got %h want fff1", p); else pass_count++;
    check_count++;
    if (lat !== 10) $display("[TB] FAIL sgn_latency got %0d want 10", lat); else pass_count++;
    applyStimulus(1'b0, 1'b1, 8'h7F, 8'h80, p, lat, bs, da);
    check_count++;
    if (p !== 16'hC080) $display("[TB] FAIL sgn_max_min got %h want c080", p); else pass_count++;
    applyStimulus(1'b0, 1'b1, 8'hFD, 8'hFD, p, lat, bs, da);
    check_count++;
    if (p !== 16'h0009) $display("[TB] FAIL sgn_m3xm3 got %h want 0009", p); else pass_count++;
    applyStimulus(1'b0, 1'b0, 8'hFD, 8'h05, p, lat, bs, da);
    check_count++;
    if (p !== 16'h04F1) $display("[TB] FAIL sgn_off_per_op got %h want 04f1", p); else pass_count++;
  endtask

  task automatic test_signed_disabled();
    logic [15:0] p; int lat; logic bs; logic da;
    applyStimulus(1'b1, 1'b1, 8'hFD, 8'h05, p, lat, bs, da);
    check_count++;
    if (p !== 16'h04F1) $display("[TB] FAIL nosgn_fdx05 got %h want 04f1", p); else pass_count++;
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF, p, lat, bs, da);
    check_count++;
    if (p !== 16'hFE01) $display("[TB] FAIL nosgn_ffxff got %h want fe01", p); else pass_count++;
    check_count++;
    if (lat !== 10) $display("[TB] FAIL nosgn_latency got %0d want 10", lat); else pass_count++;
  endtask

  task automatic test_zero();
    logic [15:0] p; int lat; logic bs; logic da;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h5A, p, lat, bs, da);
    check_count++;
    if (p !== 16'h0000) $display("[TB] FAIL zero_prod got %h want 0000", p); else pass_count++;
    check_count++;
    if (lat !== 10) $display("[TB] FAIL zero_latency got %0d want 10", lat); else pass_count++;
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h80, p, lat, bs, da);
    check_count++;
    if (p !== 16'h0000) $display("[TB] FAIL zero_neg got %h want 0000", p); else pass_count++;
  endtask

  task automatic test_start_ignored();
    int dones; int first; logic [15:0] p;
    dones = 0; first = -1; p = '0;
    @(negedge clk);
    if_m8.start = 1'b1; if_m8.signed_mode = 1'b0; if_m8.a = 8'h12; if_m8.b = 8'h34;
    @(negedge clk);
    if_m8.start = 1'b0;
    repeat (2) @(negedge clk);
    if_m8.start = 1'b1; if_m8.a = 8'hFF; if_m8.b = 8'hFF;
    @(negedge clk);
    if_m8.start = 1'b0;
    for (int i = 4; i <= 26; i++) begin
      if (if_m8.done) begin
        dones++;
        if (first < 0) begin first = i; p = if_m8.prod; end
      end
      @(negedge clk);
    end
    check_count++;
    if (dones !== 1) $display("[TB] FAIL ignore_done_count got %0d want 1", dones); else pass_count++;
    check_count++;
    if (p !== 16'h03A8) $display("[TB] FAIL ignore_prod got %h want 03a8", p); else pass_count++;
    check_count++;
    if (first !== 10) $display("[TB] FAIL ignore_latency got %0d want 10", first); else pass_count++;
  endtask

  task automatic test_reset_abort();
    int dones; logic [15:0] p; int lat; logic bs; logic da;
    dones = 0;
    @(negedge clk);
    if_m8.start = 1'b1; if_m8.signed_mode = 1'b0; if_m8.a = 8'hFF; if_m8.b = 8'hFF;
    @(negedge clk);
    if_m8.start = 1'b0;
    @(negedge clk);
    check_count++;
    if (if_m8.busy !== 1'b1) $display("[TB] FAIL abort_busy_before got %b want 1", if_m8.busy);
    else pass_count++;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_count++;
    if (if_m8.busy !== 1'b0 || if_m8.done !== 1'b0 || if_m8.prod !== 16'h0000)
      $display("[TB] FAIL abort_state got busy=%b done=%b prod=%h want 0 0 0000",
               if_m8.busy, if_m8.done, if_m8.prod);
    else pass_count++;
    for (int i = 0; i < 20; i++) begin
      if (if_m8.done) dones++;
      @(negedge clk);
    end
    check_count++;
    if (dones !== 0) $display("[TB] FAIL abort_no_done got %0d want 0", dones); else pass_count++;
    applyStimulus(1'b0, 1'b0, 8'h07, 8'h09, p, lat, bs, da);
    check_count++;
    if (p !== 16'h003F) $display("[TB] FAIL abort_then_7x9 got %h want 003f", p); else pass_count++;
  endtask

  task automatic test_wide();
    logic [31:0] p; int lat;
    applyStimulus16(1'b0, 16'hFFFF, 16'hFFFF, p, lat);
    check_count++;
    if (p !== 32'hFFFE0001) $display("[TB] FAIL w16_ffff got %h want fffe0001", p); else pass_count++;
    check_count++;
    if (lat !== 18) $display("[TB] FAIL w16_latency got %0d want 18", lat); else pass_count++;
    applyStimulus16(1'b1, 16'h8000, 16'h8000, p, lat);
    check_count++;
    if (p !== 32'h40000000) $display("[TB] FAIL w16_min_min got %h want 40000000", p); else pass_count++;
    applyStimulus16(1'b1, 16'hFFFF, 16'hFFFF, p, lat);
    check_count++;
    if (p !== 32'h00000001) $display("[TB] FAIL w16_m1xm1 got %h want 00000001", p); else pass_count++;
  endtask

  // Start held high: accepts land 19 edges apart, and the first product must
  // stay visible while the second (different) operation is still calculating.
  task automatic test_back_to_back();
    int dones; int t[3]; logic [31:0] pr[3]; logic [31:0] mid;
    dones = 0; mid = '0;
    for (int k = 0; k < 3; k++) begin t[k] = -1; pr[k] = '0; end
    @(negedge clk);
    if_m16.start = 1'b1; if_m16.signed_mode = 1'b0; if_m16.a = 16'hFFFF; if_m16.b = 16'hFFFF;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (i == 1) begin if_m16.a = 16'h0003; if_m16.b = 16'h0005; end
      if (i == 25) mid = if_m16.prod;
      if (if_m16.done) begin
        if (dones < 3) begin t[dones] = i; pr[dones] = if_m16.prod; end
        dones++;
      end
    end
    if_m16.start = 1'b0;
    repeat (25) @(negedge clk);
    check_count++;
    if (dones !== 3) $display("[TB] FAIL b2b_done_count got %0d want 3", dones); else pass_count++;
    check_count++;
    if (t[0] !== 18 || t[1] !== 37 || t[2] !== 56)
      $display("[TB] FAIL b2b_timing got %0d,%0d,%0d want 18,37,56", t[0], t[1], t[2]);
    else pass_count++;
    check_count++;
    if (pr[0] !== 32'hFFFE0001) $display("[TB] FAIL b2b_first got %h want fffe0001", pr[0]);
    else pass_count++;
    check_count++;
    if (mid !== 32'hFFFE0001) $display("[TB] FAIL b2b_hold got %h want fffe0001", mid);
    else pass_count++;
    check_count++;
    if (pr[1] !== 32'h0000000F || pr[2] !== 32'h0000000F)
      $display("[TB] FAIL b2b_next got %h,%h want 0000000f,0000000f", pr[1], pr[2]);
    else pass_count++;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset = 1'b0;
    if_m8.start = 1'b0;  if_m8.signed_mode = 1'b0;  if_m8.a = '0;  if_m8.b = '0;
    if_u8.start = 1'b0;  if_u8.signed_mode = 1'b0;  if_u8.a = '0;  if_u8.b = '0;
    if_m16.start = 1'b0; if_m16.signed_mode = 1'b0; if_m16.a = '0; if_m16.b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_signed_disabled();
    test_zero();
    test_start_ignored();
    test_reset_abort();
    test_wide();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
